// File: rtl/fixed_pri_dispatcher_pkg.sv
// Package fixed_pri_pkg: shared helpers for the fixed-priority dispatcher.
//   clog2p1    : number of bits needed to hold a count of 0..n
//   onehot_lsb : isolate the lowest set bit of a vector (up to 32 bits)
//   onehot2idx : binary index of a one-hot vector (up to 32 bits)
package fixed_pri_pkg;

   localparam int MAX_WORKERS = 32;

   function automatic int clog2p1(input int n);
      return $clog2(n + 1);
   endfunction

   // Two's-complement trick: vec & -vec keeps only the least significant 1.
   function automatic logic [MAX_WORKERS-1:0] onehot_lsb(input logic [MAX_WORKERS-1:0] vec);
      return vec & (~vec + 32'd1);
   endfunction

   function automatic logic [4:0] onehot2idx(input logic [MAX_WORKERS-1:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_WORKERS; i++) begin
         if (oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/fixed_pri_dispatcher_free_pick.sv
// fp_free_pick: combinational picker choosing the lowest-indexed free slot.
// Ports:
//   free_i       : per-slot free flags (~busy)
//   sel_onehot_o : one-hot of the lowest free slot (0 when none free)
//   sel_idx_o    : binary index of that slot
//   any_free_o   : at least one slot is free
module fp_free_pick
   import fixed_pri_pkg::*;
#(
   parameter int WORKERS = 4,
   parameter int IDX_W   = $clog2(WORKERS)
) (
   input  logic [WORKERS-1:0] free_i,
   output logic [WORKERS-1:0] sel_onehot_o,
   output logic [IDX_W-1:0]   sel_idx_o,
   output logic               any_free_o
);

   logic [MAX_WORKERS-1:0] oh_full;
   logic [4:0]             idx_full;
   logic                   unused_hi;

   // Work at the package's fixed 32-bit width, then narrow to WORKERS.
   assign oh_full      = onehot_lsb(MAX_WORKERS'(free_i));
   assign idx_full     = onehot2idx(oh_full);
   assign sel_onehot_o = oh_full[WORKERS-1:0];
   assign sel_idx_o    = idx_full[IDX_W-1:0];
   assign any_free_o   = |free_i;

   // Upper bits are always zero for WORKERS < 32.
   assign unused_hi    = ^{oh_full, idx_full};

endmodule

// File: rtl/fixed_pri_dispatcher.sv
// fixed_pri_dispatcher: accepts jobs from one valid/ready source and launches
// each on the lowest-indexed idle worker (index 0 = highest priority).
// Handshake: a job is accepted on a rising edge where in_valid_i & in_ready_o;
// in_ready_o depends only on en_i and registered busy state, never on
// in_valid_i or done_i; the producer holds data stable while not ready.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en_i          : dispatch enable (busy slots still complete when low)
//   in_valid_i/in_data_i/in_ready_o : job input handshake
//   disp_valid_o  : one-hot, one-cycle launch pulse per worker
//   disp_data_o   : payload of the launched job (holds when idle)
//   disp_idx_o    : index of the launched worker (holds when idle)
//   done_i        : per-worker completion pulses
//   busy_o        : registered busy vector
//   busy_cnt_o    : popcount of busy_o
//   err_o         : sticky flag, set by done on an idle worker
module fixed_pri_dispatcher
   import fixed_pri_pkg::*;
#(
   parameter  int WORKERS = 4,
   parameter  int DATA_W  = 8,
   localparam int IDX_W   = $clog2(WORKERS),
   localparam int CNT_W   = clog2p1(WORKERS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic               in_valid_i,
   input  logic [DATA_W-1:0]  in_data_i,
   output logic               in_ready_o,
   output logic [WORKERS-1:0] disp_valid_o,
   output logic [DATA_W-1:0]  disp_data_o,
   output logic [IDX_W-1:0]   disp_idx_o,
   input  logic [WORKERS-1:0] done_i,
   output logic [WORKERS-1:0] busy_o,
   output logic [CNT_W-1:0]   busy_cnt_o,
   output logic               err_o
);

   logic [WORKERS-1:0] busy_q, busy_d;
   logic [WORKERS-1:0] disp_valid_q, disp_valid_d;
   logic [DATA_W-1:0]  disp_data_q, disp_data_d;
   logic [IDX_W-1:0]   disp_idx_q, disp_idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic [WORKERS-1:0] sel_oh;
   logic [IDX_W-1:0]   sel_idx;
   logic               any_free;
   logic               accept;

   fp_free_pick #(
      .WORKERS (WORKERS),
      .IDX_W   (IDX_W)
   ) u_pick (
      .free_i       (~busy_q),
      .sel_onehot_o (sel_oh),
      .sel_idx_o    (sel_idx),
      .any_free_o   (any_free)
   );

   assign in_ready_o = en_i & any_free;
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      // The picked slot is idle, so a done on it cannot occur; clearing
      // and setting never collide on the same bit.
      busy_d       = (busy_q & ~done_i) | (accept ? sel_oh : '0);
      disp_valid_d = accept ? sel_oh : '0;
      disp_data_d  = accept ? in_data_i : disp_data_q;
      disp_idx_d   = accept ? sel_idx : disp_idx_q;
      err_d        = err_q | (|(done_i & ~busy_q));
      cnt_d        = '0;
      for (int i = 0; i < WORKERS; i++) begin
         cnt_d = cnt_d + CNT_W'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= '0;
         disp_valid_q <= '0;
         disp_data_q  <= '0;
         disp_idx_q   <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         disp_valid_q <= disp_valid_d;
         disp_data_q  <= disp_data_d;
         disp_idx_q   <= disp_idx_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign busy_o       = busy_q;
   assign disp_valid_o = disp_valid_q;
   assign disp_data_o  = disp_data_q;
   assign disp_idx_o   = disp_idx_q;
   assign busy_cnt_o   = cnt_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_fixed_pri_dispatcher.sv
// Bench for fixed_pri_dispatcher (WORKERS=4, DATA_W=8): vector table,
// hand-written reset sequence, and a randomised phase against a small model.
module tb_fixed_pri_dispatcher;

   localparam int WORKERS = 4;
   localparam int DATA_W  = 8;

   typedef struct packed {
      logic       en;
      logic       valid;
      logic [7:0] data;
      logic [3:0] done;
      logic       ready;
      logic [3:0] dv;
      logic [1:0] idx;
      logic [7:0] dd;
      logic [3:0] busy;
      logic [2:0] cnt;
      logic       err;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       en_i;
   logic       in_valid_i;
   logic [7:0] in_data_i;
   logic       in_ready_o;
   logic [3:0] disp_valid_o;
   logic [7:0] disp_data_o;
   logic [1:0] disp_idx_o;
   logic [3:0] done_i;
   logic [3:0] busy_o;
   logic [2:0] busy_cnt_o;
   logic       err_o;

   int   errors = 0;
   int   checks = 0;
   vec_t exp_q[$];
   vec_t tbl[20];

   fixed_pri_dispatcher #(
      .WORKERS (WORKERS),
      .DATA_W  (DATA_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en_i),
      .in_valid_i   (in_valid_i),
      .in_data_i    (in_data_i),
      .in_ready_o   (in_ready_o),
      .disp_valid_o (disp_valid_o),
      .disp_data_o  (disp_data_o),
      .disp_idx_o   (disp_idx_o),
      .done_i       (done_i),
      .busy_o       (busy_o),
      .busy_cnt_o   (busy_cnt_o),
      .err_o        (err_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A worker is never told done in the cycle it is launched.
   always @(posedge clk) begin
      if (rst_n) begin
         assert ((disp_valid_o & done_i) == 4'b0)
            else $error("FAIL launch_done_overlap: dv=%b done=%b", disp_valid_o, done_i);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic valid, input logic [7:0] data,
                               input logic [3:0] done, input logic ready, input logic [3:0] dv,
                               input logic [1:0] idx, input logic [7:0] dd, input logic [3:0] busy,
                               input logic [2:0] cnt, input logic err);
      vec_t v;
      v.en = en; v.valid = valid; v.data = data; v.done = done;
      v.ready = ready; v.dv = dv; v.idx = idx; v.dd = dd;
      v.busy = busy; v.cnt = cnt; v.err = err;
      return v;
   endfunction

   // ---------------- driver + scoreboard ----------------
   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      en_i       = v.en;
      in_valid_i = v.valid;
      in_data_i  = v.data;
      done_i     = v.done;
      #1;
      chk("in_ready", 32'(in_ready_o), 32'(v.ready));
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("disp_valid", 32'(disp_valid_o), 32'(e.dv));
      chk("disp_idx",   32'(disp_idx_o),   32'(e.idx));
      chk("disp_data",  32'(disp_data_o),  32'(e.dd));
      chk("busy",       32'(busy_o),       32'(e.busy));
      chk("busy_cnt",   32'(busy_cnt_o),   32'(e.cnt));
      chk("err",        32'(err_o),        32'(e.err));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},     32'(busy_o),       32'h0);
      chk({tag, "_dv"},       32'(disp_valid_o), 32'h0);
      chk({tag, "_data"},     32'(disp_data_o),  32'h0);
      chk({tag, "_idx"},      32'(disp_idx_o),   32'h0);
      chk({tag, "_cnt"},      32'(busy_cnt_o),   32'h0);
      chk({tag, "_err"},      32'(err_o),        32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] m_busy, m_dv, m_done, nb;
      logic [1:0] m_idx;
      logic [7:0] m_data, r_data;
      logic       r_en, r_valid, r_ready, acc, hold;
      int         sel;

      //             en val data   done    rdy dv      idx dd     busy    cnt err
      tbl[0]  = mk(1, 1, 8'hA1, 4'b0000, 1, 4'b0001, 0, 8'hA1, 4'b0001, 1, 0);
      tbl[1]  = mk(1, 1, 8'hA2, 4'b0000, 1, 4'b0010, 1, 8'hA2, 4'b0011, 2, 0);
      tbl[2]  = mk(1, 1, 8'hA3, 4'b0000, 1, 4'b0100, 2, 8'hA3, 4'b0111, 3, 0);
      tbl[3]  = mk(1, 1, 8'hA4, 4'b0000, 1, 4'b1000, 3, 8'hA4, 4'b1111, 4, 0);
      tbl[4]  = mk(1, 1, 8'hB5, 4'b0100, 0, 4'b0000, 3, 8'hA4, 4'b1011, 3, 0);
      tbl[5]  = mk(1, 1, 8'hB5, 4'b0000, 1, 4'b0100, 2, 8'hB5, 4'b1111, 4, 0);
      tbl[6]  = mk(1, 0, 8'h00, 4'b1001, 0, 4'b0000, 2, 8'hB5, 4'b0110, 2, 0);
      tbl[7]  = mk(1, 1, 8'hC1, 4'b0000, 1, 4'b0001, 0, 8'hC1, 4'b0111, 3, 0);
      tbl[8]  = mk(1, 1, 8'hC2, 4'b0000, 1, 4'b1000, 3, 8'hC2, 4'b1111, 4, 0);
      tbl[9]  = mk(1, 0, 8'h00, 4'b0100, 0, 4'b0000, 3, 8'hC2, 4'b1011, 3, 0);
      tbl[10] = mk(1, 0, 8'h00, 4'b1000, 1, 4'b0000, 3, 8'hC2, 4'b0011, 2, 0);
      tbl[11] = mk(1, 1, 8'hD1, 4'b0001, 1, 4'b0100, 2, 8'hD1, 4'b0110, 2, 0);
      tbl[12] = mk(1, 1, 8'hD2, 4'b0000, 1, 4'b0001, 0, 8'hD2, 4'b0111, 3, 0);
      tbl[13] = mk(0, 1, 8'hE1, 4'b0000, 0, 4'b0000, 0, 8'hD2, 4'b0111, 3, 0);
      tbl[14] = mk(0, 1, 8'hE1, 4'b0010, 0, 4'b0000, 0, 8'hD2, 4'b0101, 2, 0);
      tbl[15] = mk(1, 0, 8'h00, 4'b0101, 1, 4'b0000, 0, 8'hD2, 4'b0000, 0, 0);
      tbl[16] = mk(1, 0, 8'h00, 4'b1000, 1, 4'b0000, 0, 8'hD2, 4'b0000, 0, 1);
      tbl[17] = mk(1, 1, 8'hF1, 4'b0000, 1, 4'b0001, 0, 8'hF1, 4'b0001, 1, 1);
      tbl[18] = mk(1, 0, 8'h00, 4'b0000, 1, 4'b0000, 0, 8'hF1, 4'b0001, 1, 1);
      tbl[19] = mk(1, 0, 8'h00, 4'b0001, 1, 4'b0000, 0, 8'hF1, 4'b0000, 0, 1);

      // reset
      rst_n      = 1'b0;
      en_i       = 1'b0;
      in_valid_i = 1'b0;
      in_data_i  = 8'h00;
      done_i     = 4'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors
      for (int i = 0; i < 20; i++) step(tbl[i]);

      // launch one job, then assert reset mid-cycle while a new job is offered
      step(mk(1, 1, 8'h77, 4'b0000, 1, 4'b0001, 0, 8'h77, 4'b0001, 1, 1));
      @(negedge clk);
      in_valid_i = 1'b1;
      in_data_i  = 8'h88;
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      #1;
      chk_all_zero("rst_held");
      @(negedge clk);
      in_valid_i = 1'b0;
      rst_n      = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("post_rst");

      // randomised traffic against a model
      m_busy = '0; m_dv = '0; m_idx = '0; m_data = '0; hold = 1'b0; r_data = '0;
      for (int n = 0; n < 80; n++) begin
         r_en    = ($urandom_range(0, 3) != 0);
         if (!hold) begin
            r_valid = 1'($urandom_range(0, 1));
            r_data  = 8'($urandom_range(0, 255));
         end else begin
            r_valid = 1'b1;
         end
         m_done  = 4'($urandom_range(0, 15)) & m_busy & ~m_dv;
         r_ready = r_en & (m_busy != 4'b1111);
         acc     = r_valid & r_ready;
         sel     = 0;
         for (int k = WORKERS - 1; k >= 0; k--) if (!m_busy[k]) sel = k;
         nb      = m_busy & ~m_done;
         m_dv    = 4'b0;
         if (acc) begin
            nb[sel] = 1'b1;
            m_dv    = 4'b1 << sel;
            m_idx   = 2'(sel);
            m_data  = r_data;
         end
         step(mk(r_en, r_valid, r_data, m_done, r_ready, m_dv, m_idx, m_data,
                 nb, 3'($countones(nb)), 1'b0));
         hold   = r_valid & ~r_ready;
         m_busy = nb;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
